// File: rtl/m_serial_addsub.sv
// m_serial_addsub: digit-serial adder/subtractor.
// Processes DIGIT bits per clock, least-significant digit first, with a
// valid/ready handshake on both the operand side and the result side.
// The finished result is published only at the last digit, so w_s,
// w_cout and w_ovf never show partial values.

module m_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_in_valid,
    output logic             w_in_ready,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    input  logic             w_cin,
    input  logic             w_sub,
    output logic             w_out_valid,
    input  logic             w_out_ready,
    output logic [WIDTH-1:0] w_s,
    output logic             w_cout,
    output logic             w_ovf,
    output logic             w_busy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    // Refuse to build with a digit size that does not tile the word.
    generate
        if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("m_serial_addsub: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;       // remaining addend digits, LSD at bit 0
    logic [WIDTH-1:0] b_q;       // remaining (possibly inverted) operand digits
    logic [WIDTH-1:0] acc_q;     // partial result, digits enter from the MSB side
    logic             carry_q;   // carry between digits
    logic [CNT_W-1:0] cnt_q;     // index of the digit being processed
    logic [WIDTH-1:0] s_q;       // published result
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] digit_sum;
    logic             ripple_c;
    logic             carry_out;
    logic             carry_msb;
    logic [WIDTH-1:0] acc_next;

    // Ripple-add the low digit of both operands with the stored carry.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
        digit_sum = '0;
        ripple_c  = carry_q;
        carry_msb = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                carry_msb = ripple_c;
            end
            digit_sum[i] = a_q[i] ^ b_q[i] ^ ripple_c;
            ripple_c     = (a_q[i] & b_q[i]) | (ripple_c & (a_q[i] ^ b_q[i]));
        end
        carry_out = ripple_c;
    end

    // Shift the new digit into the result from the top.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign acc_next = digit_sum;
        end else begin : g_multi_digit
            assign acc_next = {digit_sum, acc_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Control FSM and datapath registers; reset wins over any handshake.
    always_ff @(posedge w_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (w_rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_in_valid) begin
                        a_q     <= w_a;
                        b_q     <= w_sub ? ~w_b : w_b;
                        carry_q <= w_sub ? ~w_cin : w_cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_next;
                    carry_q <= carry_out;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        s_q    <= acc_next;
                        cout_q <= carry_out;
                        ovf_q  <= carry_out ^ carry_msb;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (w_out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign w_in_ready  = (state == IDLE);
    assign w_out_valid = (state == DONE);
    assign w_busy      = (state != IDLE);
    assign w_s         = s_q;
    assign w_cout      = cout_q;
    assign w_ovf       = ovf_q;

endmodule

// File: tb/tb_m_serial_addsub.sv
// tb_m_serial_addsub: self-checking bench for m_serial_addsub.
// Three instances (1x1, 8x1, 16x4) share operand buses; each has its own
// handshake signals. Expected results come from a plain-arithmetic model.

module tb_m_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [2:0]  iv, ordy;
    wire  [2:0]  irdy, ovld, bsy, co, ov;
    wire         s1;
    wire  [7:0]  s8;
    wire  [15:0] s16;

    int total = 0;
    int bad   = 0;

    m_serial_addsub #(.WIDTH(1), .DIGIT(1)) u_dut1 (
        .w_clk(clk), .w_rst(rst), .w_in_valid(iv[0]), .w_in_ready(irdy[0]),
        .w_a(a[0:0]), .w_b(b[0:0]), .w_cin(cin), .w_sub(sub),
        .w_out_valid(ovld[0]), .w_out_ready(ordy[0]), .w_s(s1),
        .w_cout(co[0]), .w_ovf(ov[0]), .w_busy(bsy[0]));

    m_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .w_clk(clk), .w_rst(rst), .w_in_valid(iv[1]), .w_in_ready(irdy[1]),
        .w_a(a[7:0]), .w_b(b[7:0]), .w_cin(cin), .w_sub(sub),
        .w_out_valid(ovld[1]), .w_out_ready(ordy[1]), .w_s(s8),
        .w_cout(co[1]), .w_ovf(ov[1]), .w_busy(bsy[1]));

    m_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .w_clk(clk), .w_rst(rst), .w_in_valid(iv[2]), .w_in_ready(irdy[2]),
        .w_a(a), .w_b(b), .w_cin(cin), .w_sub(sub),
        .w_out_valid(ovld[2]), .w_out_ready(ordy[2]), .w_s(s16),
        .w_cout(co[2]), .w_ovf(ov[2]), .w_busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 8 : 16;
    endfunction

    function automatic int digits_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 8 : 4;
    endfunction

    function automatic logic [15:0] get_s(input int sel);
        case (sel)
            0:       return {15'd0, s1};
            1:       return {8'd0, s8};
            default: return s16;
        endcase
    endfunction

    // Reference: integer arithmetic on unsigned and signed interpretations.
    // Returns {ovf, cout, s}.
    function automatic logic [17:0] model(input int w, input logic [15:0] a_i, input logic [15:0] b_i,
                                          input logic cin_i, input logic sub_i);
        longint mask, av, bv, cv, full, sa, sb, sv, lo, hi;
        logic   cout_m, ovf_m;
        mask = (longint'(1) << w) - 1;
        av   = longint'(a_i) & mask;
        bv   = longint'(b_i) & mask;
        cv   = longint'(cin_i);
        sa   = (av >= (longint'(1) << (w - 1))) ? av - (longint'(1) << w) : av;
        sb   = (bv >= (longint'(1) << (w - 1))) ? bv - (longint'(1) << w) : bv;
        lo   = -(longint'(1) << (w - 1));
        hi   = (longint'(1) << (w - 1)) - 1;
        if (!sub_i) begin
            full   = av + bv + cv;
            cout_m = (full > mask);
            sv     = sa + sb + cv;
        end else begin
            full   = av - bv - cv;
            cout_m = (av >= bv + cv);
            sv     = sa - sb - cv;
        end
        ovf_m = (sv < lo) || (sv > hi);
        return {ovf_m, cout_m, 16'(full & mask)};
    endfunction

    // One complete operation on instance sel, checked against the model.
    task automatic do_op(input int sel, input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic cin_i, input logic sub_i, input int gap_in, input int gap_out,
                         input bit noise, output logic [15:0] got_s, output logic got_co,
                         output logic got_ov);
        logic [17:0] exp_v;
        logic [15:0] prev_s;
        int          lat;
        exp_v = model(width_of(sel), a_i, b_i, cin_i, sub_i);
        repeat (gap_in) begin
            if (noise) begin a = 16'($urandom); b = 16'($urandom); end
            @(posedge clk); #1;
        end
        check("in_ready_idle", 32'(irdy[sel]), 32'd1);
        prev_s = get_s(sel);
        a = a_i; b = b_i; cin = cin_i; sub = sub_i; iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        check("s_held_in_run", 32'(get_s(sel)), 32'(prev_s));
        lat = 0;
        while (!ovld[sel] && lat < 40) begin
            check("busy_run", 32'(bsy[sel]), 32'd1);
            if (noise) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                iv[sel] = 1'($urandom); ordy[sel] = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(digits_of(sel)));
        ordy[sel] = 1'b0;
        repeat (gap_out) begin
            if (noise) begin iv[sel] = 1'($urandom); a = 16'($urandom); end
            @(posedge clk); #1;
        end
        check("done_valid", {29'd0, ovld[sel], bsy[sel], irdy[sel]}, 32'b110);
        got_s  = get_s(sel);
        got_co = co[sel];
        got_ov = ov[sel];
        check("s", 32'(got_s), 32'(exp_v[15:0]));
        check("cout", 32'(got_co), 32'(exp_v[16]));
        check("ovf", 32'(got_ov), 32'(exp_v[17]));
        iv[sel] = 1'b0; ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        check("after_hs", {29'd0, ovld[sel], bsy[sel], irdy[sel]}, 32'b001);
        check("s_retained", 32'(get_s(sel)), 32'(exp_v[15:0]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gs;
        logic        gc, go;
        logic [1:0]  tbl [8];
        int          wait_cnt;

        tbl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        rst = 1'b1; iv = '0; ordy = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on every instance.
        for (int sel = 0; sel < 3; sel++) begin
            check("rst_ctrl", {29'd0, ovld[sel], bsy[sel], irdy[sel]}, 32'b001);
            check("rst_res", {14'd0, ov[sel], co[sel], get_s(sel)}, 32'd0);
        end

        // WIDTH=1: all eight add combinations.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_op(0, {15'd0, v[2]}, {15'd0, v[1]}, v[0], 1'b0, 0, 0, 1'b0, gs, gc, go);
            check("w1_table", {30'd0, gc, gs[0]}, {30'd0, tbl[i]});
        end

        // WIDTH=8 directed add/sub corners.
        do_op(1, 16'hFF, 16'h01, 1'b0, 1'b0, 0, 0, 1'b0, gs, gc, go);
        check("ff_plus_1", {22'd0, go, gc, gs[7:0]}, {22'd0, 1'b0, 1'b1, 8'h00});
        do_op(1, 16'h7F, 16'h01, 1'b0, 1'b0, 1, 2, 1'b0, gs, gc, go);
        check("7f_plus_1", {22'd0, go, gc, gs[7:0]}, {22'd0, 1'b1, 1'b0, 8'h80});
        do_op(1, 16'h05, 16'h07, 1'b0, 1'b1, 0, 1, 1'b0, gs, gc, go);
        check("5_minus_7", {22'd0, go, gc, gs[7:0]}, {22'd0, 1'b0, 1'b0, 8'hFE});
        do_op(1, 16'h80, 16'h01, 1'b0, 1'b1, 2, 0, 1'b0, gs, gc, go);
        check("80_minus_1", {22'd0, go, gc, gs[7:0]}, {22'd0, 1'b1, 1'b1, 8'h7F});
        do_op(1, 16'h10, 16'h01, 1'b1, 1'b1, 0, 0, 1'b0, gs, gc, go);
        check("10_minus_1_b", {23'd0, gc, gs[7:0]}, {23'd0, 1'b1, 8'h0E});

        // Back-pressure: hold result for 10 cycles while in_valid pulses.
        a = 16'h3C; b = 16'h0A; cin = 1'b0; sub = 1'b0; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        wait_cnt = 0;
        while (!ovld[1] && wait_cnt < 40) begin @(posedge clk); #1; wait_cnt++; end
        check("bp_latency", 32'(wait_cnt), 32'd8);
        for (int c = 0; c < 10; c++) begin
            iv[1] = 1'(c % 2); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            check("bp_hold_ctrl", {30'd0, ovld[1], irdy[1]}, 32'b10);
            check("bp_hold_res", {22'd0, ov[1], co[1], s8}, {22'd0, 1'b0, 1'b0, 8'h46});
            @(posedge clk); #1;
        end
        iv[1] = 1'b0; ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        check("bp_release", {29'd0, ovld[1], bsy[1], irdy[1]}, 32'b001);
        @(posedge clk); #1;
        check("bp_no_accept", {29'd0, ovld[1], bsy[1], irdy[1]}, 32'b001);
        check("bp_s_kept", 32'(s8), 32'h46);

        // Reset on the third RUN cycle discards the operation.
        a = 16'hA5; b = 16'h3C; cin = 1'b1; sub = 1'b1; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_rst_busy", 32'(bsy[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_ctrl", {29'd0, ovld[1], bsy[1], irdy[1]}, 32'b001);
        check("midrun_rst_res", {22'd0, ov[1], co[1], s8}, 32'd0);
        do_op(1, 16'h12, 16'h34, 1'b0, 1'b0, 0, 0, 1'b0, gs, gc, go);
        check("after_rst_op", 32'(gs), 32'h46);

        // WIDTH=16, DIGIT=4: randomized operations with gaps and noise.
        for (int k = 0; k < 1000; k++) begin
            do_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, gs, gc, go);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_serial_addsub.md
M_SERIAL_ADDSUB -- requirements
Module: m_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, else elaboration fails.
REQ-003 The block SHALL have port w_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port w_rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port w_in_valid  in  1  operands and mode present.
REQ-006 The block SHALL have port w_in_ready  out  1  block can accept an operation.
REQ-007 The block SHALL have ports w_a, w_b  in  WIDTH  operands, unsigned or two's complement.
REQ-008 The block SHALL have port w_cin  in  1  carry-in for add; borrow-in for subtract.
REQ-009 The block SHALL have port w_sub  in  1  0 = add, 1 = subtract.
REQ-010 The block SHALL have port w_out_valid  out  1  result present.
REQ-011 The block SHALL have port w_out_ready  in  1  consumer takes result.
REQ-012 The block SHALL have port w_s  out  WIDTH  sum/difference.
REQ-013 The block SHALL have port w_cout  out  1  carry out of MSB.
REQ-014 The block SHALL have port w_ovf  out  1  signed overflow.
REQ-015 The block SHALL have port w_busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-017 In IDLE: w_in_ready=1, w_out_valid=0; accept occurs at an edge with w_in_valid=1 and w_in_ready=1.
REQ-018 On accept: capture w_a; capture w_b, inverted if w_sub=1; initial carry = w_cin if w_sub=0, else ~w_cin; digit counter=0; next state RUN.
REQ-019 The inputs w_a, w_b, w_cin and w_sub SHALL be ignored except at an accept edge; w_in_valid SHALL be ignored outside IDLE.
REQ-020 Each RUN edge SHALL ripple-add the low DIGIT bits of the captured operands with the stored carry, shift the DIGIT result bits in from the MSB side of the result register, shift the operands right by DIGIT, update the carry and increment the counter.
REQ-021 After the N-th RUN edge, the next state SHALL be DONE; w_out_valid SHALL rise exactly N edges after the accept edge (N=1 when DIGIT=WIDTH).
REQ-022 Result SHALL equal (a + b + cin) mod 2^WIDTH for add and (a - b - cin) mod 2^WIDTH for subtract.
REQ-023 w_cout SHALL be the raw MSB carry; for subtract, 1 means no borrow.
REQ-024 w_ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, captured at the final digit.
REQ-025 In DONE: w_out_valid=1, w_in_ready=0, and w_s/w_cout/w_ovf SHALL hold stable while w_out_ready=0.
REQ-026 At an edge in DONE with w_out_ready=1, the next state SHALL be IDLE; w_in_ready rises the following cycle, with no same-cycle result-to-accept pass-through.
REQ-027 w_s, w_cout and w_ovf SHALL retain the last result through IDLE until the next DONE and SHALL NOT show partial values as final outputs.
REQ-028 w_out_ready SHALL have no effect outside DONE.

Reset
REQ-029 At an edge with w_rst=1, regardless of state (including mid-RUN or DONE), the block SHALL go to IDLE and clear the counter, carry, operand and result registers.
REQ-030 After reset: w_in_ready=1, w_out_valid=0, w_busy=0, w_s=0, w_cout=0, w_ovf=0; an in-flight operation SHALL be discarded.
REQ-031 w_rst SHALL take priority over a simultaneous accept or result handshake.

Verification
REQ-032 WIDTH=1, DIGIT=1, all 8 (a,b,cin) add combos -> {cout,s} = 00,01,01,10,01,10,10,11; out_valid 1 edge after accept.
REQ-033 WIDTH=8, DIGIT=1 add: FF+01+0 -> s=00, cout=1, ovf=0; 7F+01+0 -> s=80, cout=0, ovf=1; out_valid exactly 8 edges after accept.
REQ-034 WIDTH=8 sub: 05-07-0 -> s=FE, cout=0, ovf=0; 80-01-0 -> s=7F, cout=1, ovf=1; 10-01-1 -> s=0E, cout=1.
REQ-035 Back-pressure: hold w_out_ready=0 for 10 cycles in DONE and pulse w_in_valid -> out_valid and outputs stable, in_ready=0, no new accept; release -> IDLE next cycle.
REQ-036 Reset on the 3rd RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, s=0; the following operation 12+34 -> 46 is correct.
REQ-037 WIDTH=16, DIGIT=4: 1000 random add/sub ops with random valid/ready gaps -> match the reference model; latency 4 edges; busy is high from accept through handshake.
